// File: rtl/wb_arbiter_stage_if.sv
// Bus bundle for wb_arbiter_stage: result channels in, register-file
// write port and retire interface out.
// slave  = the writeback stage side, master = the producer/consumer side.
`timescale 1ns/1ps
interface wb_arbiter_stage_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 3,
  parameter int RIDX_WIDTH = 5,
  parameter int CNT_WIDTH  = 64
);
  logic                               flush;
  logic [NUM_SRC-1:0]                 src_valid;
  logic [NUM_SRC-1:0]                 src_ready;
  logic [NUM_SRC*RIDX_WIDTH-1:0]      src_rd;
  logic [NUM_SRC*DATA_WIDTH-1:0]      src_data;
  logic [NUM_SRC*(ADDR_WIDTH-2)-1:0]  src_addr;
  logic                               rf_we;
  logic [RIDX_WIDTH-1:0]              rf_waddr;
  logic [DATA_WIDTH-1:0]              rf_wdata;
  logic                               retire_valid;
  logic [ADDR_WIDTH-3:0]              retire_addr;
  logic [CNT_WIDTH-1:0]               retire_count;

  modport slave (
    input  flush, src_valid, src_rd, src_data, src_addr,
    output src_ready, rf_we, rf_waddr, rf_wdata,
           retire_valid, retire_addr, retire_count
  );

  modport master (
    output flush, src_valid, src_rd, src_data, src_addr,
    input  src_ready, rf_we, rf_waddr, rf_wdata,
           retire_valid, retire_addr, retire_count
  );
endinterface

// File: rtl/wb_arbiter_stage.sv
// wb_arbiter_stage: round-robin writeback stage. Accepts one completed
// result per cycle from NUM_SRC channels, registers it onto the
// register-file write port and retire interface, and counts retirements.
// Optional feature macro: WB_TRACE_EN (simulation retire trace).
`timescale 1ns/1ps
module wb_arbiter_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 3,
  parameter int RIDX_WIDTH = 5,
  parameter int CNT_WIDTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  wb_arbiter_stage_if.slave bus
);
  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int IA_W  = ADDR_WIDTH - 2;

  // Per-channel views of the packed payload buses
  logic [RIDX_WIDTH-1:0] src_rd_arr   [NUM_SRC];
  logic [DATA_WIDTH-1:0] src_data_arr [NUM_SRC];
  logic [IA_W-1:0]       src_addr_arr [NUM_SRC];

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] grant;
  logic [PTR_W-1:0] cand;
  logic             grant_en;
  logic             xfer;

  logic                  rf_we_q,        rf_we_d;
  logic [RIDX_WIDTH-1:0] rf_waddr_q,     rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q,     rf_wdata_d;
  logic                  retire_valid_q, retire_valid_d;
  logic [IA_W-1:0]       retire_addr_q,  retire_addr_d;
  logic [CNT_WIDTH-1:0]  retire_count_q, retire_count_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_chan
      assign src_rd_arr[gi]   = bus.src_rd[gi*RIDX_WIDTH +: RIDX_WIDTH];
      assign src_data_arr[gi] = bus.src_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign src_addr_arr[gi] = bus.src_addr[gi*IA_W +: IA_W];
      // Only the granted channel sees ready; flush suppresses every grant
      assign bus.src_ready[gi] = grant_en && (grant == PTR_W'(gi));
    end
  endgenerate

  // Round-robin pick: scan from rr_ptr upward; the nearest valid wins,
  // so walk the offsets from farthest to nearest and let later hits overwrite
  always_comb begin
    grant = '0;
    cand  = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_SRC);
      if (bus.src_valid[cand]) grant = cand;
    end
  end

  assign grant_en = (|bus.src_valid) && !bus.flush;
  assign xfer     = |(bus.src_valid & bus.src_ready);

  // Next-state for pointer and registered writeback/retire outputs
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    rf_we_d        = 1'b0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    retire_valid_d = 1'b0;
    retire_addr_d  = retire_addr_q;
    retire_count_d = retire_count_q;
    if (xfer) begin
      // Wraps to 0 after the last channel; stays 0 for a single channel
      rr_ptr_d       = (grant == PTR_W'(NUM_SRC - 1)) ? '0 : grant + PTR_W'(1);
      rf_we_d        = (src_rd_arr[grant] != '0);
      rf_waddr_d     = src_rd_arr[grant];
      rf_wdata_d     = src_data_arr[grant];
      retire_valid_d = 1'b1;
      retire_addr_d  = src_addr_arr[grant];
      retire_count_d = retire_count_q + CNT_WIDTH'(1);
    end
  end

  // State registers; reset drops any result captured but not yet written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      retire_valid_q <= 1'b0;
      retire_addr_q  <= '0;
      retire_count_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      retire_valid_q <= retire_valid_d;
      retire_addr_q  <= retire_addr_d;
      retire_count_q <= retire_count_d;
    end
  end

  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.retire_valid = retire_valid_q;
  assign bus.retire_addr  = retire_addr_q;
  assign bus.retire_count = retire_count_q;

`ifdef WB_TRACE_EN
  logic [PTR_W-1:0] trace_src_q, trace_src_d;

  // Remember which channel produced the registered result
  always_comb begin
    trace_src_d = trace_src_q;
    if (xfer) trace_src_d = grant;
  end

  // Trace source register, cleared with the rest of the stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trace_src_q <= '0;
    else     trace_src_q <= trace_src_d;
  end

  // Simulation log line for each retired instruction
  always @(posedge clk) begin
    if (!rst && retire_valid_q)
      $display("%t WB: src=%0d addr=%h rd=%0d data=%h we=%0d", $time, trace_src_q,
               {retire_addr_q, 2'b00}, rf_waddr_q, rf_wdata_q, rf_we_q);
  end
`endif

endmodule
